// File: rtl/debounce_bank.sv
// debounce_bank: per-channel two-flop synchroniser and consecutive-sample
// filter giving a clean pressed-high level plus one-cycle rise/fall pulses.
module debounce_bank #(
   parameter int CHANNELS        = 4,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_WIDTH       = 20,
   parameter int ACTIVE_LOW      = 0
) (
   input  logic                clk_in,
   input  logic                rst,
   input  logic [CHANNELS-1:0] btn_in,
   output logic [CHANNELS-1:0] btn_out,
   output logic [CHANNELS-1:0] rise,
   output logic [CHANNELS-1:0] fall,
   output logic                any_rise
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX =
      CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
   localparam logic [CHANNELS-1:0] POL =
      (ACTIVE_LOW != 0) ? '1 : '0;

   logic [CHANNELS-1:0] s1;
   logic [CHANNELS-1:0] s2;
   logic [CHANNELS-1:0] accept;

   // Normalise polarity, then two-stage synchroniser for the raw inputs.
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= btn_in ^ POL;
         s2 <= s1;
      end
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic                 stable;
      logic                 rise_q;
      logic                 fall_q;
      logic [CNT_WIDTH-1:0] cnt;

      // Accept the new level once it has persisted the full window.
      assign accept[i] = (s2[i] != stable) && (cnt == CNT_MAX);

      // Count consecutive differing samples; any agreeing sample restarts.
      always_ff @(posedge clk_in or posedge rst) begin
         if (rst) begin
            stable <= 1'b0;
            cnt    <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
         end else begin
            rise_q <= accept[i] & s2[i];
            fall_q <= accept[i] & ~s2[i];
            if (s2[i] == stable || accept[i]) begin
               cnt <= '0;
            end else begin
               cnt <= cnt + CNT_WIDTH'(1);
            end
            if (accept[i]) begin
               stable <= s2[i];
            end
         end
      end

      assign btn_out[i] = stable;
      assign rise[i]    = rise_q;
      assign fall[i]    = fall_q;
   end

   // Summary rise pulse, aligned with the per-channel rise bits.
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         any_rise <= 1'b0;
      end else begin
         any_rise <= |(accept & s2);
      end
   end

endmodule
